count_sequence_monitor: RTL

// - Receive-side checker for the up/down loadable counter. Samples the counter's q output every

---
 rtl/count_sequence_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/count_sequence_monitor.sv
// Observes an up/down loadable counter's output, locks onto its counting direction
// and reports wraps, parallel loads and direction violations.
module count_sequence_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             valid,
  output logic             locked,
  output logic             dir_up,
  output logic             wrap_pulse,
  output logic             jump_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned       STREAK_W = 8;
  localparam logic [STREAK_W-1:0] LOCK_V = STREAK_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0]  ONE_V    = WIDTH'(1);
  localparam logic [WIDTH-1:0]  MAX_V    = '1;

  typedef enum logic [1:0] {
    ACQUIRE    = 2'd0,
    TRACK_UP   = 2'd1,
    TRACK_DOWN = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt, w_streak_inc;
  logic                r_streak_up, w_streak_up_nxt;
  logic [WIDTH-1:0]    r_prev;
  logic                r_have_prev;
  logic                r_locked, r_dir_up, r_wrap, r_jump, r_err;
  logic [ERR_W-1:0]    r_err_count;

  logic [WIDTH-1:0] w_delta;
  logic             w_classify, w_up, w_down, w_jump_step, w_wrap;
  logic             w_err, w_jump;

  // Step classification against the previous accepted sample
  assign w_classify  = valid && r_have_prev;
  assign w_delta     = q_in - r_prev;
  assign w_up        = (w_delta == ONE_V);
  assign w_down      = (w_delta == MAX_V);
  assign w_jump_step = !w_up && !w_down && (w_delta != '0);
  assign w_wrap      = (w_up && (r_prev == MAX_V) && (q_in == '0)) ||
                       (w_down && (r_prev == '0) && (q_in == MAX_V));

  // Direction acquisition / tracking FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_streak_nxt    = r_streak;
    w_streak_up_nxt = r_streak_up;
    w_streak_inc    = '0;
    w_err           = 1'b0;
    w_jump          = 1'b0;
    case (r_state)
      ACQUIRE: begin
        if (w_classify) begin
          if (w_up || w_down) begin
            w_streak_inc = ((r_streak != '0) && (r_streak_up == w_up)) ?
                           r_streak + STREAK_W'(1) : STREAK_W'(1);
            if (w_streak_inc >= LOCK_V) begin
              w_state_nxt  = w_up ? TRACK_UP : TRACK_DOWN;
              w_streak_nxt = '0;
            end else begin
              w_streak_nxt    = w_streak_inc;
              w_streak_up_nxt = w_up;
            end
          end else if (w_jump_step) begin
            w_streak_nxt = '0;
          end
        end
      end
      TRACK_UP: begin
        if (w_classify) begin
          if (w_down) begin
            w_err           = 1'b1;
            w_state_nxt     = ACQUIRE;
            w_streak_nxt    = STREAK_W'(1);
            w_streak_up_nxt = 1'b0;
          end else if (w_jump_step) begin
            w_jump = 1'b1;
          end
        end
      end
      TRACK_DOWN: begin
        if (w_classify) begin
          if (w_up) begin
            w_err           = 1'b1;
            w_state_nxt     = ACQUIRE;
            w_streak_nxt    = STREAK_W'(1);
            w_streak_up_nxt = 1'b1;
          end else if (w_jump_step) begin
            w_jump = 1'b1;
          end
        end
      end
      default: w_state_nxt = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACQUIRE;
      r_streak    <= '0;
      r_streak_up <= 1'b0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_locked    <= 1'b0;
      r_dir_up    <= 1'b0;
      r_wrap      <= 1'b0;
      r_jump      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_streak    <= w_streak_nxt;
      r_streak_up <= w_streak_up_nxt;
      r_locked    <= (w_state_nxt != ACQUIRE);
      r_dir_up    <= (w_state_nxt == TRACK_UP);
      r_wrap      <= w_classify && w_wrap;
      r_jump      <= w_jump;
      r_err       <= w_err;
      if (valid) begin
        r_prev      <= q_in;
        r_have_prev <= 1'b1;
      end
      // Error total saturates rather than wrapping
      if (w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign locked     = r_locked;
  assign dir_up     = r_dir_up;
  assign wrap_pulse = r_wrap;
  assign jump_pulse = r_jump;
  assign err_pulse  = r_err;
  assign err_count  = r_err_count;

endmodule
